mem_port_adapter: RTL

- Sits directly downstream of the multicycle controller/datapath memory port. Consumes mem_read, mem_write, mem_byte_enable, address and write data, and drives a variable-latency word-addressed physical memory.
- Aligns addresses, shifts byte lanes for sub-word stores and registers all memory-side outputs.
- Returns a single-cycle mem_resp with registered read data.
- Detects protocol conflicts, misaligned accesses and memory timeouts.

---
 rtl/mem_port_adapter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_port_adapter.sv
// Adapter between the CPU memory port and a variable-latency word-addressed memory.
// It aligns each access and shifts its byte lanes, registers the memory-side outputs, and keeps sticky error flags.
module mem_port_adapter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        err_conflict
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      RD_POISON  = 32'hDEADBEEF;

    logic [1:0]       state_q, state_d;
    logic             op_wr_q, op_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] addr_d, wdata_d, rdata_d;
    logic [3:0]  be_d;
    logic        rd_d, wr_d, resp_d;
    logic        mis_d, to_d, conf_d;

    logic [7:0]  be_shift_c;
    logic [31:0] wdata_shift_c;
    logic        timeout_hit_c;

    // Lane shift of the incoming request; bits above lane 3 indicate a store crossing the word
    assign be_shift_c    = {4'b0000, mem_byte_enable} << mem_address[1:0];
    assign wdata_shift_c = mem_wdata << {mem_address[1:0], 3'b000};

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        op_wr_d       = op_wr_q;
        cnt_d         = cnt_q;
        addr_d        = pmem_address;
        wdata_d       = pmem_wdata;
        be_d          = pmem_byte_enable;
        rdata_d       = mem_rdata;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        resp_d        = 1'b0;
        mis_d         = err_misalign;
        to_d          = err_timeout;
        conf_d        = err_conflict;
        timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    conf_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    state_d = ST_ACCESS;
                    op_wr_d = mem_write;
                    cnt_d   = '0;
                    addr_d  = {mem_address[31:2], 2'b00};
                    wdata_d = wdata_shift_c;
                    be_d    = be_shift_c[3:0];
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    mis_d   = err_misalign | (mem_write & (|be_shift_c[7:4]));
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the timeout cycle takes priority over the abort
                if (pmem_resp) begin
                    if (!op_wr_q) begin
                        rdata_d = pmem_rdata;
                    end
                    resp_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (timeout_hit_c) begin
                    to_d = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d = RD_POISON;
                    end
                    resp_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rd_d = !op_wr_q;
                    wr_d = op_wr_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            op_wr_q          <= 1'b0;
            cnt_q            <= '0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            mem_rdata        <= '0;
            mem_resp         <= 1'b0;
            err_misalign     <= 1'b0;
            err_timeout      <= 1'b0;
            err_conflict     <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_wr_q          <= op_wr_d;
            cnt_q            <= cnt_d;
            pmem_address     <= addr_d;
            pmem_wdata       <= wdata_d;
            pmem_byte_enable <= be_d;
            pmem_read        <= rd_d;
            pmem_write       <= wr_d;
            mem_rdata        <= rdata_d;
            mem_resp         <= resp_d;
            err_misalign     <= mis_d;
            err_timeout      <= to_d;
            err_conflict     <= conf_d;
        end
    end

endmodule
